sar_search_8bit: RTL and testbench

- Sequential successive-approximation search engine. Drives the A operand of an external combinational 8-bit magnitude comparator and reads back its LT/GT/Eq flags.
- The comparator's B operand is tied to an unknown target value; the block binary-searches the target MSB-first and reports it.
- It is the driving end of the comparator interface: it generates operands and consumes relation flags. It is used for threshold finding and as a self-checking harness for the comparator.

---
 rtl/sar_search_8bit.sv | 125 ++++++++++++
 tb/tb_sar_search_8bit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_8bit.sv
// Successive-approximation search that drives a magnitude comparator's A operand, MSB first.
// One compare per cycle, done pulses WIDTH+1 cycles after start at worst; start is ignored unless IDLE.
module sar_search_8bit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] trial,
   input  logic             cmp_lt,
   input  logic             cmp_gt,
   input  logic             cmp_eq,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             cmp_err
);

   localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TEST = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] trial_d, result_d, upd;
   logic             busy_d, done_d, found_d, err_d;
   logic             flags_onehot;
   logic [KW-1:0]    k_m1;

   // Exactly one of three: odd parity excludes zero and two set, the AND term excludes all three.
   assign flags_onehot = (cmp_lt ^ cmp_gt ^ cmp_eq) & ~(cmp_lt & cmp_gt & cmp_eq);
   assign k_m1         = k_q - 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= KW'(WIDTH - 1);
         trial   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         found   <= 1'b0;
         cmp_err <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         trial   <= trial_d;
         busy    <= busy_d;
         done    <= done_d;
         result  <= result_d;
         found   <= found_d;
         cmp_err <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      trial_d  = trial;
      busy_d   = busy;
      done_d   = 1'b0;
      result_d = result;
      found_d  = found;
      err_d    = cmp_err;
      upd      = trial;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               trial_d            = '0;
               trial_d[WIDTH-1]   = 1'b1;
               k_d                = KW'(WIDTH - 1);
               found_d            = 1'b0;
               err_d              = 1'b0;
               busy_d             = 1'b1;
               state_d            = TEST;
            end
         end
         TEST: begin
            if (!flags_onehot) begin
               result_d = '0;
               found_d  = 1'b0;
               err_d    = 1'b1;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = DONE;
            end else if (cmp_eq) begin
               result_d = trial;
               found_d  = 1'b1;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = DONE;
            end else begin
               // Candidate too large: drop this bit; too small: keep it.
               if (cmp_gt) upd[k_q] = 1'b0;
               if (k_q == '0) begin
                  trial_d  = upd;
                  result_d = upd;
                  found_d  = 1'b0;
                  busy_d   = 1'b0;
                  done_d   = 1'b1;
                  state_d  = DONE;
               end else begin
                  upd[k_m1] = 1'b1;
                  trial_d   = upd;
                  k_d       = k_m1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sar_search_8bit.sv
// Directed bench for sar_search_8bit with a behavioural comparator on the trial bus.
module tb_sar_search_8bit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] trial;
   logic       cmp_lt, cmp_gt, cmp_eq;
   logic       busy, done, found, cmp_err;
   logic [7:0] result;

   logic [7:0] target_r = 8'd0;
   logic       force_bad = 1'b0;

   int errors = 0;
   int checks = 0;

   logic [7:0] trial_log [16];
   int         n_trials, done_cyc, done_cnt;
   logic [7:0] cap_result;
   logic       cap_found, cap_err;

   always #5 clk = ~clk;

   assign cmp_lt = force_bad ? 1'b1 : (trial < target_r);
   assign cmp_gt = force_bad ? 1'b1 : (trial > target_r);
   assign cmp_eq = force_bad ? 1'b0 : (trial == target_r);

   sar_search_8bit #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .trial   (trial),
      .cmp_lt  (cmp_lt),
      .cmp_gt  (cmp_gt),
      .cmp_eq  (cmp_eq),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .found   (found),
      .cmp_err (cmp_err)
   );

   // Start edge ends cycle 0; cycle c is the period after the c-th following edge.
   // start_mask[c] drives start during cycle c; bad_at forces non-one-hot flags in that cycle.
   task automatic do_search(input logic [7:0] target, input logic [15:0] start_mask, input int bad_at);
      target_r = target;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_trials = 0;
      done_cnt = 0;
      done_cyc = 0;
      for (int c = 1; c <= 14; c++) begin
         start     = start_mask[c];
         force_bad = (bad_at == c);
         if (busy && n_trials < 16) begin
            trial_log[n_trials] = trial;
            n_trials++;
         end
         if (done) begin
            done_cnt++;
            done_cyc   = c;
            cap_result = result;
            cap_found  = found;
            cap_err    = cmp_err;
         end
         @(negedge clk);
      end
      start     = 1'b0;
      force_bad = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (trial   !== 8'd0) begin errors++; $display("FAIL reset_trial got %0d want 0", trial); end
      checks++; if (busy    !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done    !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (result  !== 8'd0) begin errors++; $display("FAIL reset_result got %0d want 0", result); end
      checks++; if (found   !== 1'b0) begin errors++; $display("FAIL reset_found got %b want 0", found); end
      checks++; if (cmp_err !== 1'b0) begin errors++; $display("FAIL reset_cmp_err got %b want 0", cmp_err); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_target_100;
      logic [7:0] exp [6] = '{8'd128, 8'd64, 8'd96, 8'd112, 8'd104, 8'd100};
      do_search(8'd100, 16'h0000, 0);
      checks++; if (n_trials != 6) begin errors++; $display("FAIL t100_ntrials got %0d want 6", n_trials); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (trial_log[i] !== exp[i]) begin errors++; $display("FAIL t100_trial[%0d] got %0d want %0d", i, trial_log[i], exp[i]); end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL t100_done_count got %0d want 1", done_cnt); end
      checks++; if (done_cyc != 7) begin errors++; $display("FAIL t100_done_cycle got %0d want 7", done_cyc); end
      checks++; if (cap_result !== 8'd100) begin errors++; $display("FAIL t100_result got %0d want 100", cap_result); end
      checks++; if (cap_found !== 1'b1) begin errors++; $display("FAIL t100_found got %b want 1", cap_found); end
      checks++; if (cap_err !== 1'b0) begin errors++; $display("FAIL t100_cmp_err got %b want 0", cap_err); end
      checks++; if (trial !== 8'd100) begin errors++; $display("FAIL t100_trial_hold got %0d want 100", trial); end
   endtask

   task automatic test_target_255;
      logic [7:0] exp [8] = '{8'd128, 8'd192, 8'd224, 8'd240, 8'd248, 8'd252, 8'd254, 8'd255};
      do_search(8'd255, 16'h0000, 0);
      checks++; if (n_trials != 8) begin errors++; $display("FAIL t255_ntrials got %0d want 8", n_trials); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (trial_log[i] !== exp[i]) begin errors++; $display("FAIL t255_trial[%0d] got %0d want %0d", i, trial_log[i], exp[i]); end
      end
      checks++; if (done_cyc != 9) begin errors++; $display("FAIL t255_done_cycle got %0d want 9", done_cyc); end
      checks++; if (cap_result !== 8'd255) begin errors++; $display("FAIL t255_result got %0d want 255", cap_result); end
      checks++; if (cap_found !== 1'b1) begin errors++; $display("FAIL t255_found got %b want 1", cap_found); end
   endtask

   task automatic test_boundaries;
      logic [7:0] exp0 [8] = '{8'd128, 8'd64, 8'd32, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1};
      do_search(8'd128, 16'h0000, 0);
      checks++; if (done_cyc != 2) begin errors++; $display("FAIL t128_done_cycle got %0d want 2", done_cyc); end
      checks++; if (cap_result !== 8'd128) begin errors++; $display("FAIL t128_result got %0d want 128", cap_result); end
      checks++; if (cap_found !== 1'b1) begin errors++; $display("FAIL t128_found got %b want 1", cap_found); end
      do_search(8'd0, 16'h0000, 0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (trial_log[i] !== exp0[i]) begin errors++; $display("FAIL t0_trial[%0d] got %0d want %0d", i, trial_log[i], exp0[i]); end
      end
      checks++; if (done_cyc != 9) begin errors++; $display("FAIL t0_done_cycle got %0d want 9", done_cyc); end
      checks++; if (cap_result !== 8'd0) begin errors++; $display("FAIL t0_result got %0d want 0", cap_result); end
      checks++; if (cap_found !== 1'b0) begin errors++; $display("FAIL t0_found got %b want 0", cap_found); end
      checks++; if (cap_err !== 1'b0) begin errors++; $display("FAIL t0_cmp_err got %b want 0", cap_err); end
      checks++; if (trial !== 8'd0) begin errors++; $display("FAIL t0_trial_hold got %0d want 0", trial); end
   endtask

   task automatic test_cmp_error;
      do_search(8'd100, 16'h0000, 3);
      checks++; if (n_trials != 3) begin errors++; $display("FAIL err_ntrials got %0d want 3", n_trials); end
      checks++; if (done_cyc != 4) begin errors++; $display("FAIL err_done_cycle got %0d want 4", done_cyc); end
      checks++; if (cap_err !== 1'b1) begin errors++; $display("FAIL err_cmp_err got %b want 1", cap_err); end
      checks++; if (cap_result !== 8'd0) begin errors++; $display("FAIL err_result got %0d want 0", cap_result); end
      checks++; if (cap_found !== 1'b0) begin errors++; $display("FAIL err_found got %b want 0", cap_found); end
      do_search(8'd100, 16'h0000, 0);
      checks++; if (cap_err !== 1'b0) begin errors++; $display("FAIL err_clear_cmp_err got %b want 0", cap_err); end
      checks++; if (cap_result !== 8'd100) begin errors++; $display("FAIL err_clear_result got %0d want 100", cap_result); end
   endtask

   task automatic test_ignored_start;
      // Extra start pulses in cycles 2 and 4 (busy) and 7 (the done cycle).
      do_search(8'd100, 16'h0094, 0);
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", done_cnt); end
      checks++; if (n_trials != 6) begin errors++; $display("FAIL ign_ntrials got %0d want 6", n_trials); end
      checks++; if (done_cyc != 7) begin errors++; $display("FAIL ign_done_cycle got %0d want 7", done_cyc); end
      checks++; if (cap_result !== 8'd100) begin errors++; $display("FAIL ign_result got %0d want 100", cap_result); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_after got %b want 0", busy); end
   endtask

   task automatic test_reset_mid;
      int stray;
      target_r = 8'd100;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (trial   !== 8'd0) begin errors++; $display("FAIL rst_mid_trial got %0d want 0", trial); end
      checks++; if (busy    !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
      checks++; if (result  !== 8'd0) begin errors++; $display("FAIL rst_mid_result got %0d want 0", result); end
      checks++; if (found   !== 1'b0) begin errors++; $display("FAIL rst_mid_found got %b want 0", found); end
      stray = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done !== 1'b0) stray++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) stray++;
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d stray cycles want 0", stray); end
      do_search(8'd100, 16'h0000, 0);
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rst_mid_resume_done got %0d want 1", done_cnt); end
      checks++; if (cap_result !== 8'd100) begin errors++; $display("FAIL rst_mid_resume_result got %0d want 100", cap_result); end
      checks++; if (cap_found !== 1'b1) begin errors++; $display("FAIL rst_mid_resume_found got %b want 1", cap_found); end
   endtask

   initial begin
      test_reset;
      test_target_100;
      test_target_255;
      test_boundaries;
      test_cmp_error;
      test_ignored_start;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
